// File: rtl/pe_prec_acc.sv
// Two-stage precision-switchable multiply-accumulate PE: one signed ACTxWGT product, or NUM_LANES
// packed unsigned-byte x signed-byte products. Fixed 2-cycle latency, no backpressure.
module pe_prec_acc #(
  parameter int ACT_WIDTH    = 16,
  parameter int WGT_WIDTH    = 16,
  parameter int PE_OUT_WIDTH = 48,
  parameter int SATURATE     = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          in_valid,
  input  logic [ACT_WIDTH-1:0]          a,
  input  logic [WGT_WIDTH-1:0]          b,
  input  logic [PE_OUT_WIDTH-1:0]       c,
  input  logic                          choose_8bit,
  input  logic                          acc_sel,
  input  logic                          acc_clear,
  output logic [PE_OUT_WIDTH-1:0]       out,
  output logic                          out_valid,
  output logic [ACT_WIDTH/8-1:0]        sat_flag
);
  localparam int NUM_LANES = ACT_WIDTH / 8;
  localparam int LANE_W    = PE_OUT_WIDTH / NUM_LANES;
  localparam int PROD_W    = ACT_WIDTH + WGT_WIDTH;
  localparam int FULL_W    = ((PROD_W > PE_OUT_WIDTH) ? PROD_W : PE_OUT_WIDTH) + 1;

  localparam logic [PE_OUT_WIDTH-1:0] FULL_MAX = {1'b0, {(PE_OUT_WIDTH-1){1'b1}}};
  localparam logic [PE_OUT_WIDTH-1:0] FULL_MIN = {1'b1, {(PE_OUT_WIDTH-1){1'b0}}};
  localparam logic [LANE_W-1:0]       LANE_MAX = {1'b0, {(LANE_W-1){1'b1}}};
  localparam logic [LANE_W-1:0]       LANE_MIN = {1'b1, {(LANE_W-1){1'b0}}};

  // Stage 1 products: both modes are formed every beat; the registered mode picks one.
  logic signed [PROD_W-1:0]       a_ext, b_ext, prod_full;
  logic [NUM_LANES-1:0][16:0]     lane_prod;

  always_comb begin
    a_ext     = {{WGT_WIDTH{a[ACT_WIDTH-1]}}, a};
    b_ext     = {{ACT_WIDTH{b[WGT_WIDTH-1]}}, b};
    prod_full = a_ext * b_ext;
    lane_prod = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_prod[i] = $signed({9'b0, a[8*i +: 8]}) * $signed({{9{b[7]}}, b[7:0]});
    end
  end

  logic                           s1_vld, s1_mode, s1_sel, s1_clr;
  logic [PROD_W-1:0]              s1_prod;
  logic [NUM_LANES-1:0][16:0]     s1_lane_prod;
  logic [PE_OUT_WIDTH-1:0]        s1_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld       <= 1'b0;
      s1_mode      <= 1'b0;
      s1_sel       <= 1'b0;
      s1_clr       <= 1'b0;
      s1_prod      <= '0;
      s1_lane_prod <= '0;
      s1_c         <= '0;
    end else begin
      s1_vld <= in_valid;
      if (in_valid) begin
        s1_mode      <= choose_8bit;
        s1_sel       <= acc_sel;
        s1_clr       <= acc_clear;
        s1_prod      <= prod_full;
        s1_lane_prod <= lane_prod;
        s1_c         <= c;
      end
    end
  end

  // Stage 2: addend comes straight from the out register, so back-to-back accumulates need no bubble.
  logic [PE_OUT_WIDTH-1:0]        addend, full_res, lane_res;
  logic [FULL_W-1:0]              full_sum;
  logic                           full_ovf;
  logic [NUM_LANES-1:0][LANE_W:0] lane_sum;
  logic [NUM_LANES-1:0]           lane_ovf;

  always_comb begin
    addend   = s1_clr ? '0 : (s1_sel ? out : s1_c);
    full_sum = {{(FULL_W-PROD_W){s1_prod[PROD_W-1]}}, s1_prod}
             + {{(FULL_W-PE_OUT_WIDTH){addend[PE_OUT_WIDTH-1]}}, addend};
    full_ovf = !((&full_sum[FULL_W-1:PE_OUT_WIDTH-1]) || !(|full_sum[FULL_W-1:PE_OUT_WIDTH-1]));
    if (full_ovf && (SATURATE != 0))
      full_res = full_sum[FULL_W-1] ? FULL_MIN : FULL_MAX;
    else
      full_res = full_sum[PE_OUT_WIDTH-1:0];

    lane_sum = '0;
    lane_ovf = '0;
    lane_res = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_sum[i] = {{(LANE_W-16){s1_lane_prod[i][16]}}, s1_lane_prod[i]}
                  + {addend[i*LANE_W+LANE_W-1], addend[i*LANE_W +: LANE_W]};
      lane_ovf[i] = lane_sum[i][LANE_W] ^ lane_sum[i][LANE_W-1];
      if (lane_ovf[i] && (SATURATE != 0))
        lane_res[i*LANE_W +: LANE_W] = lane_sum[i][LANE_W] ? LANE_MIN : LANE_MAX;
      else
        lane_res[i*LANE_W +: LANE_W] = lane_sum[i][LANE_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out       <= '0;
      out_valid <= 1'b0;
      sat_flag  <= '0;
    end else begin
      out_valid <= s1_vld;
      if (s1_vld) begin
        out      <= s1_mode ? lane_res : full_res;
        sat_flag <= (s1_clr ? '0 : sat_flag)
                  | (s1_mode ? lane_ovf : {{(NUM_LANES-1){1'b0}}, full_ovf});
      end
    end
  end
endmodule

// File: tb/tb_pe_prec_acc.sv
// Scoreboard bench for pe_prec_acc (default parameters): directed vectors plus a
// mixed-mode sequence checked against an integer reference model.
module tb_pe_prec_acc;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [15:0] a, b;
  logic [47:0] c;
  logic        choose_8bit, acc_sel, acc_clear;
  logic [47:0] out;
  logic        out_valid;
  logic [1:0]  sat_flag;

  pe_prec_acc dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .a(a), .b(b), .c(c),
    .choose_8bit(choose_8bit), .acc_sel(acc_sel), .acc_clear(acc_clear),
    .out(out), .out_valid(out_valid), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [47:0] o;
    logic [1:0]  s;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [47:0] m_out = '0;
  logic [1:0]  m_sat = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference: wide integer arithmetic with explicit range clamping.
  function automatic exp_t model(input logic mode, input logic [15:0] av, input logic [15:0] bv,
                                 input logic [47:0] cv, input logic sel, input logic clr);
    exp_t        e;
    logic [47:0] add;
    longint      s, lo, hi, lane;
    int          ua, sb;
    add = clr ? 48'd0 : (sel ? m_out : cv);
    e.s = clr ? 2'b00 : m_sat;
    e.o = '0;
    if (!mode) begin
      lo = -(64'sd1 <<< 47);
      hi = (64'sd1 <<< 47) - 1;
      s  = longint'($signed(av)) * longint'($signed(bv)) + longint'($signed(add));
      if (s > hi) begin e.o = hi[47:0]; e.s[0] = 1'b1; end
      else if (s < lo) begin e.o = lo[47:0]; e.s[0] = 1'b1; end
      else e.o = s[47:0];
    end else begin
      lo = -(64'sd1 <<< 23);
      hi = (64'sd1 <<< 23) - 1;
      for (int i = 0; i < 2; i++) begin
        ua   = int'(av[8*i +: 8]);
        sb   = int'($signed(bv[7:0]));
        lane = longint'($signed(add[24*i +: 24]));
        s    = longint'(ua * sb) + lane;
        if (s > hi) begin e.o[24*i +: 24] = hi[23:0]; e.s[i] = 1'b1; end
        else if (s < lo) begin e.o[24*i +: 24] = lo[23:0]; e.s[i] = 1'b1; end
        else e.o[24*i +: 24] = s[23:0];
      end
    end
    return e;
  endfunction

  // use_exp=1 pushes the hand-computed value; push=0 models a beat that reset will discard.
  task automatic beat(input logic mode, input logic [15:0] av, input logic [15:0] bv,
                      input logic [47:0] cv, input logic sel, input logic clr,
                      input logic use_exp, input logic [47:0] eo, input logic [1:0] es,
                      input logic push);
    exp_t e;
    e = model(mode, av, bv, cv, sel, clr);
    if (use_exp) begin
      e.o = eo;
      e.s = es;
    end
    if (push) begin
      exp_q.push_back(e);
      m_out = e.o;
      m_sat = e.s;
    end
    in_valid = 1'b1; choose_8bit = mode; a = av; b = bv; c = cv;
    acc_sel = sel; acc_clear = clr;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && out_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_out_valid: out_valid=1 with no beat pending, required 0");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out", {16'd0, out}, {16'd0, e.o});
        check("sat_flag", {62'd0, sat_flag}, {62'd0, e.s});
      end
    end
  end

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; c = '0;
    choose_8bit = 1'b0; acc_sel = 1'b0; acc_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", {16'd0, out}, 64'd0);
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_sat", {62'd0, sat_flag}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // 16-bit signed: -3 * 1000 + 5
    beat(1'b0, 16'hFFFD, 16'd1000, 48'd5, 1'b0, 1'b0, 1'b1, -48'sd2995, 2'b00, 1'b1);
    idle(3);
    // 8-bit lanes: 255*-2+100 and 2*-2+10, no carry across lanes
    beat(1'b1, 16'h02FF, 16'h00FE, {24'd10, 24'd100}, 1'b0, 1'b0,
         1'b1, {24'd6, 24'hFFFE66}, 2'b00, 1'b1);
    idle(2);
    // Back-to-back local accumulate: 1,2,3,4 on consecutive cycles
    beat(1'b0, 16'd1, 16'd1, 48'd999, 1'b1, 1'b1, 1'b1, 48'd1, 2'b00, 1'b1);
    beat(1'b0, 16'd1, 16'd1, 48'd999, 1'b1, 1'b0, 1'b1, 48'd2, 2'b00, 1'b1);
    beat(1'b0, 16'd1, 16'd1, 48'd999, 1'b1, 1'b0, 1'b1, 48'd3, 2'b00, 1'b1);
    beat(1'b0, 16'd1, 16'd1, 48'd999, 1'b1, 1'b0, 1'b1, 48'd4, 2'b00, 1'b1);
    idle(4);
    check("hold_out", {16'd0, out}, 64'd4);
    check("hold_out_valid", {63'd0, out_valid}, 64'd0);
    // Lane 0 positive saturation, lane 1 passes c through
    beat(1'b1, 16'h00FF, 16'h007F, {24'h000123, 24'h7FFFFF}, 1'b0, 1'b0,
         1'b1, {24'h000123, 24'h7FFFFF}, 2'b01, 1'b1);
    // Sticky flag survives a clean beat
    beat(1'b1, 16'h0000, 16'h0005, 48'd0, 1'b0, 1'b0, 1'b1, 48'd0, 2'b01, 1'b1);
    // acc_clear drops the flag and zeroes the addend
    beat(1'b1, 16'h0101, 16'h0001, 48'hFFFFFF_FFFFFF, 1'b1, 1'b1,
         1'b1, {24'd1, 24'd1}, 2'b00, 1'b1);
    // 16-bit negative saturation: min + (1 * -1)
    beat(1'b0, 16'h0001, 16'hFFFF, 48'h8000_0000_0000, 1'b0, 1'b0,
         1'b1, 48'h8000_0000_0000, 2'b01, 1'b1);
    // acc_clear beat whose own result overflows nothing
    beat(1'b0, 16'h0002, 16'h0003, 48'd0, 1'b0, 1'b1, 1'b1, 48'd6, 2'b00, 1'b1);
    idle(3);

    // Mixed-mode back-to-back beats against the reference model
    for (int i = 0; i < 24; i++) begin
      logic [47:0] rc;
      rc = {16'($urandom), 32'($urandom)};
      beat(i[0], 16'($urandom), 16'($urandom), rc, 1'($urandom), ($urandom_range(3) == 0),
           1'b0, 48'd0, 2'b00, 1'b1);
    end
    idle(4);

    // Reset while a beat sits in stage 1
    beat(1'b0, 16'd7, 16'd9, 48'd1, 1'b0, 1'b0, 1'b0, 48'd0, 2'b00, 1'b0);
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    m_out = '0;
    m_sat = '0;
    idle(3);
    check("post_reset_out", {16'd0, out}, 64'd0);
    check("post_reset_sat", {62'd0, sat_flag}, 64'd0);
    check("post_reset_out_valid", {63'd0, out_valid}, 64'd0);

    // First beat after reset: out_valid exactly two edges after in_valid is sampled
    beat(1'b0, 16'd3, 16'd4, 48'd10, 1'b0, 1'b0, 1'b1, 48'd22, 2'b00, 1'b1);
    check("latency_gap", {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    #1;
    check("latency_strobe", {63'd0, out_valid}, 64'd1);
    idle(3);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pe_prec_acc.md
PE_PREC_ACC -- requirements
Module: pe_prec_acc

Interface
REQ-001 Parameter ACT_WIDTH, default 16: activation width; SHALL be a multiple of 8 and at least 16.
REQ-002 Parameter WGT_WIDTH, default 16: weight width; SHALL be at least 8.
REQ-003 Parameter PE_OUT_WIDTH, default 48: output/accumulator width; SHALL be divisible by NUM_LANES.
REQ-004 Parameter SATURATE, default 1: 1 = saturate on overflow, 0 = wrap modulo 2^width.
REQ-005 Localparams: NUM_LANES = ACT_WIDTH/8; LANE_W = PE_OUT_WIDTH/NUM_LANES, which SHALL be at least 18.
REQ-006 clk  in  1  sole clock; all state on rising edge.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 in_valid  in  1  beat qualifier; when low, no state except reset changes.
REQ-009 a  in  ACT_WIDTH  activation; signed in 16-bit mode, NUM_LANES unsigned bytes in 8-bit mode.
REQ-010 b  in  WGT_WIDTH  weight; signed full width in 16-bit mode, signed b[7:0] in 8-bit mode.
REQ-011 c  in  PE_OUT_WIDTH  signed cascade addend; packed signed LANE_W lanes in 8-bit mode.
REQ-012 choose_8bit  in  1  0 = 16-bit mode, 1 = packed 8-bit mode; sampled per beat.
REQ-013 acc_sel  in  1  0 = addend is c; 1 = addend is the current out register (local accumulate).
REQ-014 acc_clear  in  1  per beat: forces addend to zero and clears sat_flag.
REQ-015 out  out  PE_OUT_WIDTH  registered result.
REQ-016 out_valid  out  1  single-cycle strobe, high when out updated this cycle.
REQ-017 sat_flag  out  NUM_LANES  sticky per-lane overflow flags.

Function
REQ-018 Stage 1: on an in_valid cycle, register product(s), c, choose_8bit, acc_sel and acc_clear together as one beat.
REQ-019 Stage 2: one cycle later, add the registered product to the selected addend and write out; out_valid asserts in that cycle; latency is exactly 2 cycles, throughput one beat per cycle.
REQ-020 16-bit mode: product = signed a x signed b, sign-extended to PE_OUT_WIDTH, plus the addend; sat_flag[0] is the lane flag.
REQ-021 8-bit mode: lane i product = unsigned a[8i+7:8i] x signed b[7:0], sign-extended to LANE_W, plus addend lane i (out or c bits [LANE_W*(i+1)-1:LANE_W*i]).
REQ-022 No carry or borrow SHALL cross a lane boundary.
REQ-023 Overflow with SATURATE=1: clamp to the max/min signed value of the lane or full width and set the matching sat_flag bit.
REQ-024 Overflow with SATURATE=0: wrap and still set the flag.
REQ-025 acc_sel=1 with a mode different from the beat that last wrote out: the stored bits are reinterpreted per the current beat's mode with no conversion; software issues acc_clear on mode change.
REQ-026 acc_clear beat: sat_flag is cleared, then takes only that beat's overflow.
REQ-027 Back-to-back accumulate beats: each beat uses the out value written by the immediately preceding beat, with no bubble.
REQ-028 Cycles without a valid beat: out and sat_flag hold; out_valid=0.
REQ-029 Mixed-mode back-to-back beats are legal; each beat uses its own sampled mode.

Reset
REQ-030 While reset_n=0, asynchronously: out=0, out_valid=0, sat_flag=0, all pipeline registers and stage valids=0.
REQ-031 Beats in flight at reset assertion are discarded; after release, the first out_valid comes 2 cycles after the first in_valid.

Verification
REQ-032 16-bit mode: a=0xFFFD, b=1000, c=5, acc_sel=0 -> two cycles later out=-2995, out_valid one cycle, sat_flag=0.
REQ-033 8-bit mode, defaults: a=0x02FF, b=0x00FE, c lanes {10,100} -> lane0=-410 (0xFFFE66), lane1=6, with no cross-lane carry.
REQ-034 Accumulate: beat a=1,b=1,acc_sel=1,acc_clear=1, then 3 beats a=1,b=1,acc_sel=1 back-to-back -> out = 1,2,3,4 on consecutive cycles.
REQ-035 Saturation: 8-bit mode, c lane0=0x7FFFFF, a=0x00FF, b=0x007F -> lane0=0x7FFFFF, sat_flag=2'b01, lane1=c lane1; a following acc_clear beat -> flag 0.
REQ-036 Reset mid-operation: valid beat, then reset_n low for 1 cycle on the next edge -> out_valid never asserts for that beat, out=0.
REQ-037 Mode switch: alternate 16-bit and 8-bit beats every cycle with random data -> every output matches a per-beat reference model.
